sync_fifo_ctrl: RTL and testbench

Parametrised synchronous FIFO for byte and word streams between the UART receive/transmit paths and the Trivium keystream datapath. It generalises the team's single-mode FIFO with:
- non-power-of-two depth and correct pointer wrap;
- correct level tracking on simultaneous read and write;
- selectable standard or first-word-fall-through (FWFT) read mode;
- programmable almost-full/almost-empty thresholds;
- a synchronous flush;
- sticky overflow/underflow error flags.

---
 rtl/sync_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: parametrised synchronous FIFO controller.
// Depth may be any integer >= 2. Pointers wrap explicitly at DEPTH-1.
// The read port is either a registered standard port or first-word-fall-through.
// Flags are decoded from a single level register.
//
// Handshake: wr_en is a request that is accepted only when the FIFO is not full.
// rd_en is a request that is accepted only when the FIFO is not empty.
// Both conditions use the state before the clock edge. A request that is not
// accepted has no effect on the data, but it sets the matching sticky error flag.
// In FWFT mode, rd_valid qualifies rd_data, and rd_en pops the presented word.
module sync_fifo_ctrl #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;

    // Flags come from the level register alone, so they stay consistent with level.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_FULL);
    assign almost_full  = (int'(level_q) >= AFULL_THRESH);
    assign almost_empty = (int'(level_q) <= AEMPTY_THRESH);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush blocks both operations.
    // On a full FIFO, a read is still accepted while the write is dropped.
    assign wr_acc = wr_en && !full  && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    // Next-state logic for the pointers, the level and the sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (wr_en && full)  overflow_d  = 1'b1;
            if (rd_en && empty) underflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array. It has no reset; the level register alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is presented combinationally. It reads as zero while the FIFO is empty.
            assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // Registered read: capture the head word on an accepted read and pulse valid for one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Testbench for sync_fifo_ctrl: one standard-mode instance (DEPTH=10) and one FWFT instance (DEPTH=4).
module tb_sync_fifo_ctrl;

    localparam int S_DEPTH = 10;
    localparam int F_DEPTH = 4;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // standard-mode instance signals
    logic       s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_wr_data = '0;
    logic [7:0] s_rd_data;
    logic       s_rd_valid, s_empty, s_full, s_afull, s_aempty, s_overflow, s_underflow;
    logic [3:0] s_level;

    // FWFT instance signals
    logic       f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = '0;
    logic [7:0] f_rd_data;
    logic       f_rd_valid, f_empty, f_full, f_afull, f_aempty, f_overflow, f_underflow;
    logic [2:0] f_level;

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(S_DEPTH), .FWFT(0), .AFULL_THRESH(8), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
        .full(s_full), .almost_full(s_afull), .almost_empty(s_aempty), .level(s_level),
        .overflow(s_overflow), .underflow(s_underflow)
    );

    sync_fifo_ctrl #(.WIDTH(8), .DEPTH(F_DEPTH), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
        .full(f_full), .almost_full(f_afull), .almost_empty(f_aempty), .level(f_level),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // scoreboard state
    logic [7:0] exp_q[$];     // model contents, standard instance
    logic [7:0] out_q[$];     // expected read results, standard instance
    logic [7:0] f_exp_q[$];   // model contents, FWFT instance
    logic [7:0] last_rd;
    bit         m_ovf, m_udf, f_ovf, f_udf;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_std_flags();
        check_val("std_level",  32'(s_level),     32'(exp_q.size()));
        check_val("std_empty",  32'(s_empty),     32'(exp_q.size() == 0));
        check_val("std_full",   32'(s_full),      32'(exp_q.size() == S_DEPTH));
        check_val("std_afull",  32'(s_afull),     32'(exp_q.size() >= 8));
        check_val("std_aempty", 32'(s_aempty),    32'(exp_q.size() <= 2));
        check_val("std_ovf",    32'(s_overflow),  32'(m_ovf));
        check_val("std_udf",    32'(s_underflow), 32'(m_udf));
    endtask

    // One clock of stimulus on the standard instance, followed by the checks.
    task automatic std_cycle(input bit wr, input logic [7:0] wd, input bit rd, input bit fl);
        bit wacc, racc;
        s_wr_en = wr; s_wr_data = wd; s_rd_en = rd; s_flush = fl;
        wacc = !fl && wr && (exp_q.size() < S_DEPTH);
        racc = !fl && rd && (exp_q.size() > 0);
        if (fl) begin
            exp_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr && !wacc) m_ovf = 1'b1;
            if (rd && !racc) m_udf = 1'b1;
        end
        if (racc) begin
            last_rd = exp_q.pop_front();
            out_q.push_back(last_rd);
        end
        if (wacc) exp_q.push_back(wd);
        step();
        s_wr_en = 1'b0; s_rd_en = 1'b0; s_flush = 1'b0;
        check_val("std_rd_valid", 32'(s_rd_valid), 32'(racc));
        if (s_rd_valid) begin
            if (out_q.size() == 0) check_val("std_sb_pending", 32'(out_q.size()), 32'd1);
            else                   check_val("std_rd_data", 32'(s_rd_data), 32'(out_q.pop_front()));
        end
        check_val("std_rd_hold", 32'(s_rd_data), 32'(last_rd));
        check_std_flags();
    endtask

    // One clock of stimulus on the FWFT instance, followed by the checks.
    task automatic f_cycle(input bit wr, input logic [7:0] wd, input bit rd);
        bit wacc, racc;
        f_wr_en = wr; f_wr_data = wd; f_rd_en = rd;
        wacc = wr && (f_exp_q.size() < F_DEPTH);
        racc = rd && (f_exp_q.size() > 0);
        if (wr && !wacc) f_ovf = 1'b1;
        if (rd && !racc) f_udf = 1'b1;
        if (racc) void'(f_exp_q.pop_front());
        if (wacc) f_exp_q.push_back(wd);
        step();
        f_wr_en = 1'b0; f_rd_en = 1'b0;
        check_val("fw_rd_valid", 32'(f_rd_valid), 32'(f_exp_q.size() > 0));
        if (f_exp_q.size() > 0) check_val("fw_rd_data", 32'(f_rd_data), 32'(f_exp_q[0]));
        check_val("fw_level",  32'(f_level),     32'(f_exp_q.size()));
        check_val("fw_empty",  32'(f_empty),     32'(f_exp_q.size() == 0));
        check_val("fw_full",   32'(f_full),      32'(f_exp_q.size() == F_DEPTH));
        check_val("fw_afull",  32'(f_afull),     32'(f_exp_q.size() >= 3));
        check_val("fw_aempty", 32'(f_aempty),    32'(f_exp_q.size() <= 1));
        check_val("fw_ovf",    32'(f_overflow),  32'(f_ovf));
        check_val("fw_udf",    32'(f_underflow), 32'(f_udf));
    endtask

    task automatic model_reset();
        exp_q.delete(); out_q.delete(); f_exp_q.delete();
        last_rd = '0; m_ovf = 1'b0; m_udf = 1'b0; f_ovf = 1'b0; f_udf = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_std_rd_data"},  32'(s_rd_data),   32'd0);
        check_val({tag, "_std_rd_valid"}, 32'(s_rd_valid),  32'd0);
        check_val({tag, "_std_level"},    32'(s_level),     32'd0);
        check_val({tag, "_std_empty"},    32'(s_empty),     32'd1);
        check_val({tag, "_std_full"},     32'(s_full),      32'd0);
        check_val({tag, "_std_aempty"},   32'(s_aempty),    32'd1);
        check_val({tag, "_std_afull"},    32'(s_afull),     32'd0);
        check_val({tag, "_std_ovf"},      32'(s_overflow),  32'd0);
        check_val({tag, "_std_udf"},      32'(s_underflow), 32'd0);
        check_val({tag, "_fw_rd_valid"},  32'(f_rd_valid),  32'd0);
        check_val({tag, "_fw_level"},     32'(f_level),     32'd0);
        check_val({tag, "_fw_ovf"},       32'(f_overflow),  32'd0);
        check_val({tag, "_fw_udf"},       32'(f_underflow), 32'd0);
    endtask

    initial begin
        model_reset();
        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // fill 0x00..0x09, then one extra write that must be dropped
        for (int i = 0; i < S_DEPTH; i++) std_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        std_cycle(1'b1, 8'hAA, 1'b0, 1'b0);

        // drain in order, then wrap the pointers with 5 more words
        for (int i = 0; i < S_DEPTH; i++) std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) std_cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_val("std_drained_empty", 32'(s_empty), 32'd1);

        // flush at level 6 together with a write and a read
        for (int i = 0; i < 6; i++) std_cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        std_cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        std_cycle(1'b1, 8'h33, 1'b0, 1'b0);
        std_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // simultaneous read/write at level 3
        for (int i = 0; i < 3; i++) std_cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) std_cycle(1'b1, 8'(8'h63 + i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) std_cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // randomised traffic, with occasional flushes
        for (int i = 0; i < 300; i++)
            std_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));

        // FWFT: the word appears without rd_en, a pop clears it, and a pop while empty sets underflow
        f_cycle(1'b1, 8'h5A, 1'b0);
        f_cycle(1'b0, 8'h00, 1'b1);
        f_cycle(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 150; i++)
            f_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // asynchronous reset dropped between edges during continuous traffic
        for (int i = 0; i < 4; i++) std_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 8'h99;
        f_wr_en = 1'b1; f_rd_en = 1'b0; f_wr_data = 8'h77;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("arst");
        s_wr_en = 1'b0; s_rd_en = 1'b0; f_wr_en = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        std_cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        std_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        f_cycle(1'b1, 8'h3C, 1'b0);
        f_cycle(1'b0, 8'h00, 1'b1);

        check_val("std_sb_left", 32'(out_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Bound on total run time so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
